// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// Operation codes, FSM state encodings and a signed-op helper.
package mul_div_unit_pkg;

  localparam int MD_W     = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  function automatic logic is_signed_op(
    input md_op_e op
  );
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling for mul_div_unit.
// Ports: a/b operands + signed_op -> a_abs/b_abs magnitudes;
//   prod/quot/rem + latched neg flags -> sign-corrected results.
module md_sign_fix
  import mul_div_unit_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           signed_op,
  input  logic [2*W-1:0] prod,
  input  logic [W-1:0]   quot,
  input  logic [W-1:0]   rem,
  input  logic           neg_res,
  input  logic           neg_rem,
  output logic [W-1:0]   a_abs,
  output logic [W-1:0]   b_abs,
  output logic [2*W-1:0] prod_fix,
  output logic [W-1:0]   quot_fix,
  output logic [W-1:0]   rem_fix
);

  // The most negative value maps onto its own bit pattern, which is
  // the correct unsigned magnitude 2**(W-1).
  assign a_abs = (signed_op && a[W-1]) ? -a : a;
  assign b_abs = (signed_op && b[W-1]) ? -b : b;

  assign prod_fix = neg_res ? -prod : prod;
  assign quot_fix = neg_res ? -quot : quot;
  assign rem_fix  = neg_rem ? -rem  : rem;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with the HI/LO register pair.
// Ports: Start/Op/A/B launch, MtHi/MtLo/WrData writes, Busy/Done/Hi/Lo.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int W     = MD_W,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         MtHi,
  input  logic         MtLo,
  input  logic [W-1:0] WrData,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Hi,
  output logic [W-1:0] Lo
);

  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // mult: {partial product, multiplier}; div: low half is the
  // dividend shifting out while quotient bits shift in.
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     rem_q, rem_d;
  // |A| for multiply, |B| for divide.
  logic [W-1:0]   opnd_q, opnd_d;
  logic is_div_q, is_div_d;
  logic neg_res_q, neg_res_d;
  logic neg_rem_q, neg_rem_d;
  logic done_q, done_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;

  md_op_e op_e;
  logic [W-1:0]   a_abs, b_abs;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  logic [W:0]     mul_sum;
  logic [W+1:0]   div_shift;
  logic [W:0]     div_diff;
  logic           div_ok;

  assign op_e = md_op_e'(Op);

  md_sign_fix #(.W(W)) u_sign_fix (
    .a        (A),
    .b        (B),
    .signed_op(is_signed_op(op_e)),
    .prod     (acc_q),
    .quot     (acc_q[W-1:0]),
    .rem      (rem_q[W-1:0]),
    .neg_res  (neg_res_q),
    .neg_rem  (neg_rem_q),
    .a_abs    (a_abs),
    .b_abs    (b_abs),
    .prod_fix (prod_fix),
    .quot_fix (quot_fix),
    .rem_fix  (rem_fix)
  );

  // Shift-add: add multiplicand into the top half when the current
  // multiplier bit is set, keep the carry, then shift right.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring step. The full-width compare keeps divide-by-zero
  // producing all-ones even as the remainder grows past W bits.
  assign div_shift = {rem_q, acc_q[W-1]};
  assign div_ok    = div_shift >= {2'b00, opnd_q};
  assign div_diff  = div_shift[W:0] - {1'b0, opnd_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (Start) begin
          state_d   = MD_CALC;
          cnt_d     = CNT_W'(W - 1);
          is_div_d  = op_e[1];
          opnd_d    = op_e[1] ? b_abs : a_abs;
          acc_d     = {{W{1'b0}}, op_e[1] ? a_abs : b_abs};
          rem_d     = '0;
          neg_res_d = is_signed_op(op_e) & (A[W-1] ^ B[W-1]);
          neg_rem_d = (op_e == MD_DIV) & A[W-1];
        end else begin
          if (MtHi) hi_d = WrData;
          if (MtLo) lo_d = WrData;
        end
      end
      MD_CALC: begin
        if (is_div_q) begin
          rem_d = div_ok ? div_diff : div_shift[W:0];
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (cnt_q == '0) state_d = MD_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q != MD_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
